// File: rtl/ifetch.sv
// Instruction fetch unit: issues one imem read at a time, holds the fetched
// word for the decoder and handles redirects, misaligned pc and stale responses.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_adel
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] instr_nx, opc_nx;
    logic        adel_nx;
    logic        aligned;

    assign aligned   = (pc[1:0] == 2'b00);
    assign imem_addr = pc;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        instr_nx  = out_instr;
        opc_nx    = out_pc;
        adel_nx   = out_adel;
        imem_req  = 1'b0;
        out_valid = 1'b0;

        unique case (state)
            S_REQ: begin
                // The request goes out even when a redirect arrives; DROP then eats its response.
                imem_req = aligned && !reset;
                if (redirect_valid) begin
                    pc_nx    = redirect_pc;
                    state_nx = aligned ? S_DROP : S_REQ;
                end else if (aligned) begin
                    state_nx = S_WAIT;
                end else begin
                    instr_nx = 32'h0;
                    opc_nx   = pc;
                    adel_nx  = 1'b1;
                    state_nx = S_HOLD;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_nx    = redirect_pc;
                    state_nx = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    instr_nx = imem_rdata;
                    opc_nx   = pc;
                    adel_nx  = 1'b0;
                    pc_nx    = pc + 32'd4;
                    state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                out_valid = !redirect_valid;
                if (redirect_valid) begin
                    pc_nx    = redirect_pc;
                    state_nx = S_REQ;
                end else if (out_ready) begin
                    state_nx = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect_valid) begin
                    pc_nx = redirect_pc;
                end else if (imem_rvalid) begin
                    state_nx = S_REQ;
                end
            end
            default: state_nx = S_REQ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            out_instr <= 32'h0;
            out_pc    <= 32'h0;
            out_adel  <= 1'b0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            out_instr <= instr_nx;
            out_pc    <= opc_nx;
            out_adel  <= adel_nx;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: memory responder plus an architectural
// next-pc model that predicts every request address and delivered instruction.
module tb_ifetch;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_adel;

    ifetch #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_adel       (out_adel)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat = 1;
    int          mem_cnt = 0;
    bit          busy = 1'b0;
    bit          stale = 1'b0;
    bit          req_now = 1'b0;
    bit          redir_now = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] last_xfer_pc = 32'h0;
    int          n_xfer = 0;
    logic [31:0] req_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    // One clock cycle: drive inputs after the falling edge, observe 1 ns later,
    // and advance the memory responder and the architectural model.
    task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
        bit          stale_resp;
        logic [31:0] want_instr;
        @(negedge clk);
        cyc++;
        stale_resp  = 1'b0;
        imem_rvalid = 1'b0;
        if (busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr);
                busy        = 1'b0;
                stale_resp  = stale;
                stale       = 1'b0;
            end
        end
        // A redirect while DROP swallows its response would wait forever; keep them apart.
        if (rv && stale_resp) rv = 1'b0;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        redir_now      = rv;
        #1;
        req_now = imem_req;
        if (imem_req) begin
            total++;
            if (busy) begin
                bad++;
                $display("FAIL outstanding: second imem_req at cycle %0d while one pending", cyc);
            end
            total++;
            if (imem_addr !== exp_pc) begin
                bad++;
                $display("FAIL req_addr: got %h exp %h (cycle %0d)", imem_addr, exp_pc, cyc);
            end
            req_q.push_back(imem_addr);
            busy     = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = lat;
        end
        if (rv) begin
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL valid_on_redirect: got %b exp 0 (cycle %0d)", out_valid, cyc);
            end
            if (busy) stale = 1'b1;
            exp_pc = rpc;
        end else if (out_valid === 1'b1 && rdy) begin
            want_instr = (exp_pc[1:0] != 2'b00) ? 32'h0 : mem_word(exp_pc);
            total++;
            if (out_pc !== exp_pc) begin
                bad++;
                $display("FAIL xfer_pc: got %h exp %h (cycle %0d)", out_pc, exp_pc, cyc);
            end
            total++;
            if (out_instr !== want_instr) begin
                bad++;
                $display("FAIL xfer_instr: got %h exp %h (cycle %0d)", out_instr, want_instr, cyc);
            end
            total++;
            if (out_adel !== (exp_pc[1:0] != 2'b00)) begin
                bad++;
                $display("FAIL xfer_adel: got %b exp %b (cycle %0d)", out_adel, (exp_pc[1:0] != 2'b00), cyc);
            end
            n_xfer++;
            last_xfer_pc = out_pc;
            if (exp_pc[1:0] == 2'b00) exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic wait_valid();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1'b0, 32'h0, 1'b0);
            seen = (out_valid === 1'b1);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL wait_valid: got out_valid=0 after 20 cycles exp 1");
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        reset  = 1'b0;
        exp_pc = RST_PC;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        total++;
        if (imem_req !== 1'b0) begin
            bad++; $display("FAIL rst_req: got %b exp 0", imem_req);
        end
        total++;
        if (imem_addr !== RST_PC) begin
            bad++; $display("FAIL rst_addr: got %h exp %h", imem_addr, RST_PC);
        end
        total++;
        if ({out_valid, out_adel, out_instr, out_pc} !== 66'h0) begin
            bad++;
            $display("FAIL rst_out: got v=%b adel=%b instr=%h pc=%h exp all zero",
                     out_valid, out_adel, out_instr, out_pc);
        end
        release_reset();
    endtask

    task automatic test_sequential();
        int n0 = n_xfer;
        int first_req = -1;
        int first_valid = -1;
        lat = 1;
        req_q.delete();
        for (int i = 0; i < 30 && n_xfer < n0 + 3; i++) begin
            step(1'b0, 32'h0, 1'b1);
            if (req_now && first_req < 0) first_req = cyc;
            if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
        end
        total++;
        if (n_xfer - n0 != 3) begin
            bad++; $display("FAIL seq_count: got %0d exp 3", n_xfer - n0);
        end
        total++;
        if (req_q.size() < 3) begin
            bad++; $display("FAIL seq_reqs: got %0d exp >=3", req_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (req_q[k] !== RST_PC + 32'(4 * k)) begin
                    bad++; $display("FAIL seq_addr%0d: got %h exp %h", k, req_q[k], RST_PC + 32'(4 * k));
                end
            end
        end
        total++;
        if (first_valid - first_req != 2) begin
            bad++; $display("FAIL latency: got %0d exp 2", first_valid - first_req);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        int          n0;
        wait_valid();
        held = out_instr;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 1'b0);
            total++;
            if (out_valid !== 1'b1 || out_instr !== held || imem_req !== 1'b0) begin
                bad++;
                $display("FAIL hold_stable: got v=%b instr=%h req=%b exp v=1 instr=%h req=0",
                         out_valid, out_instr, imem_req, held);
            end
        end
        n0 = n_xfer;
        step(1'b0, 32'h0, 1'b1);
        total++;
        if (n_xfer != n0 + 1) begin
            bad++; $display("FAIL hold_xfer: got %0d transfers exp 1", n_xfer - n0);
        end
        step(1'b0, 32'h0, 1'b1);
        total++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1) begin
            bad++; $display("FAIL after_xfer: got v=%b req=%b exp v=0 req=1", out_valid, imem_req);
        end
    endtask

    task automatic test_redirect_wait();
        int n0;
        bit found = 1'b0;
        lat = 3;
        wait_valid();
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        total++;
        if (req_now !== 1'b1) begin
            bad++; $display("FAIL rw_req: got %b exp 1", req_now);
        end
        step(1'b1, 32'h0040_0020, 1'b1);
        n0 = n_xfer;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 32'h0, 1'b1);
            found = req_now;
        end
        total++;
        if (!found || req_q[$] !== 32'h0040_0020 || n_xfer != n0) begin
            bad++;
            $display("FAIL rw_target: got found=%b addr=%h xfers=%0d exp 1 00400020 0",
                     found, req_q[$], n_xfer - n0);
        end
        for (int i = 0; i < 20 && n_xfer == n0; i++) step(1'b0, 32'h0, 1'b1);
        total++;
        if (last_xfer_pc !== 32'h0040_0020) begin
            bad++; $display("FAIL rw_xfer: got %h exp 00400020", last_xfer_pc);
        end
    endtask

    task automatic test_misaligned();
        lat = 1;
        wait_valid();
        step(1'b1, 32'h0040_0022, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        total++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL adel_req: got req=%b v=%b exp 0 0", imem_req, out_valid);
        end
        step(1'b0, 32'h0, 1'b0);
        total++;
        if ({out_valid, out_adel, imem_req} !== 3'b110 || out_instr !== 32'h0 || out_pc !== 32'h0040_0022) begin
            bad++;
            $display("FAIL adel_out: got v=%b adel=%b req=%b instr=%h pc=%h exp 1 1 0 00000000 00400022",
                     out_valid, out_adel, imem_req, out_instr, out_pc);
        end
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out_adel !== 1'b1) begin
            bad++; $display("FAIL adel_repeat: got v=%b adel=%b exp 1 1", out_valid, out_adel);
        end
        step(1'b1, 32'h0040_0100, 1'b0);
    endtask

    task automatic test_squash();
        lat = 1;
        step(1'b0, 32'h0, 1'b0);
        total++;
        if (req_now !== 1'b1) begin
            bad++; $display("FAIL sq_req: got %b exp 1", req_now);
        end
        step(1'b1, 32'h0040_1000, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        total++;
        if (req_now !== 1'b1 || imem_addr !== 32'h0040_1000) begin
            bad++; $display("FAIL sq_resume1: got req=%b addr=%h exp 1 00401000", req_now, imem_addr);
        end
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        total++;
        if (out_valid !== 1'b1) begin
            bad++; $display("FAIL sq_hold: got %b exp 1", out_valid);
        end
        step(1'b1, 32'h0040_2000, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        total++;
        if (req_now !== 1'b1 || imem_addr !== 32'h0040_2000) begin
            bad++; $display("FAIL sq_resume2: got req=%b addr=%h exp 1 00402000", req_now, imem_addr);
        end
        for (int i = 0; i < 10 && out_valid !== 1'b1; i++) step(1'b0, 32'h0, 1'b1);
        total++;
        if (last_xfer_pc !== 32'h0040_2000) begin
            bad++; $display("FAIL sq_xfer: got %h exp 00402000", last_xfer_pc);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        lat = 3;
        wait_valid();
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        #2;
        reset          = 1'b1;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        busy           = 1'b0;
        stale          = 1'b0;
        #1;
        total++;
        if ({imem_req, out_valid, out_adel} !== 3'b000 || out_instr !== 32'h0 || out_pc !== 32'h0) begin
            bad++;
            $display("FAIL mid_rst: got req=%b v=%b adel=%b instr=%h pc=%h exp all zero",
                     imem_req, out_valid, out_adel, out_instr, out_pc);
        end
        total++;
        if (imem_addr !== RST_PC) begin
            bad++; $display("FAIL mid_rst_addr: got %h exp %h", imem_addr, RST_PC);
        end
        repeat (2) @(negedge clk);
        release_reset();
        req_q.delete();
        for (int i = 0; i < 5 && !found; i++) begin
            step(1'b0, 32'h0, 1'b1);
            found = req_now;
        end
        total++;
        if (!found || req_q[0] !== RST_PC) begin
            bad++; $display("FAIL mid_first_req: got found=%b addr=%h exp 1 %h", found, req_q[0], RST_PC);
        end
    endtask

    task automatic test_random();
        int          n0 = n_xfer;
        int          idle = 0;
        int          last_n;
        bit          rv;
        bit          rdy;
        logic [31:0] tgt;
        for (int i = 0; i < 1500; i++) begin
            lat = int'($urandom_range(1, 4));
            rv  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            tgt = $urandom;
            tgt[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            last_n = n_xfer;
            step(rv, tgt, rdy);
            if (redir_now || n_xfer != last_n) idle = 0;
            else idle++;
            if (idle > 40) begin
                total++;
                bad++;
                $display("FAIL rand_stall: got no progress for %0d cycles exp <=40", idle);
                break;
            end
        end
        total++;
        if (n_xfer - n0 < 100) begin
            bad++; $display("FAIL rand_progress: got %0d transfers exp >=100", n_xfer - n0);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_misaligned();
        test_squash();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
